// File: rtl/uart_fmt_printer_if.sv
// Purpose: request/status/serial bundle between a message source and uart_fmt_printer.
// Latency: n/a (wires only).
// Backpressure: start is honoured only while ready is high; tx is a free-running UART line.
`timescale 1ns/1ps
interface uart_fmt_printer_if #(
    parameter int DIN_W = 8
);
    logic             start;
    logic [DIN_W-1:0] din;
    logic             ready;
    logic             done;
    logic             tx;

    // Source side: issues print requests and watches progress.
    modport master (
        output start,
        output din,
        input  ready,
        input  done,
        input  tx
    );

    // Printer side.
    modport slave (
        input  start,
        input  din,
        output ready,
        output done,
        output tx
    );
endinterface

// File: rtl/uart_fmt_printer.sv
// Purpose: prints a fixed template over 8N1 UART, expanding slot-marker bytes into hex digits of captured slots.
// Latency: first start bit 1 clock after the accepting edge; 10*DIV+1 clocks per character; done 1 clock after last stop bit.
// Backpressure: ready drops for the whole message; start and din are ignored until ready returns high.
`timescale 1ns/1ps
module uart_fmt_printer #(
    parameter int                          CLOCK_FREQUENCY = 200000000,
    parameter int                          BAUD_RATE       = 9600,
    parameter int                          FORMAT_SLOTS    = 2,
    parameter int                          SLOT_DIGITS     = 1,
    parameter int                          FORMAT_STR_LEN  = 22,
    parameter logic [8*FORMAT_STR_LEN-1:0] FORMAT_STRING   = "Button R\1C\2 Pressed!\r\n",
    parameter bit                          LOWERCASE       = 1'b0,
    parameter bit                          ZERO_SUPPRESS   = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    uart_fmt_printer_if.slave bus
);

    localparam int DIV    = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int SLOT_W = 4 * SLOT_DIGITS;
    localparam int DIN_W  = SLOT_W * FORMAT_SLOTS;
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W  = $clog2(FORMAT_STR_LEN + 1);
    localparam int DIG_W  = (SLOT_DIGITS > 1) ? $clog2(SLOT_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t             state;
    logic [DIN_W-1:0]   slot_q;
    logic [IDX_W-1:0]   char_idx;
    logic [DIG_W-1:0]   digit_idx;   // next digit to emit while expanding a slot marker
    logic               in_ph;       // a slot expansion is part-way through
    logic [7:0]         sh_q;        // data bits still to shift out, ones fill behind for the stop bit
    logic [3:0]         bit_cnt;     // 0 start, 1..8 data, 9 stop
    logic [BAUD_W-1:0]  baud_cnt;

    logic [7:0]         cur_char;
    logic               cur_is_ph;
    logic [SLOT_W-1:0]  cur_slot;
    logic [DIG_W-1:0]   first_digit;
    logic [DIG_W-1:0]   sel_digit;
    logic [3:0]         nib;
    logic [7:0]         out_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return (LOWERCASE ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
    endfunction

    // Resolve the byte to send next: template byte as-is, or the selected hex digit of a slot.
    always_comb begin
        cur_char = 8'h00;
        for (int k = 0; k < FORMAT_STR_LEN; k++) begin
            if (char_idx == IDX_W'(k))
                cur_char = FORMAT_STRING[8*(FORMAT_STR_LEN-1-k) +: 8];
        end
        cur_is_ph = (cur_char != 8'h00) && (cur_char <= 8'(FORMAT_SLOTS));

        cur_slot = '0;
        for (int s = 0; s < FORMAT_SLOTS; s++) begin
            if (cur_char == 8'(s + 1))
                cur_slot = slot_q[SLOT_W*s +: SLOT_W];
        end

        // Highest digit to print: the top digit, or with suppression the top non-zero one (digit 0 if all zero).
        first_digit = '0;
        for (int d = 0; d < SLOT_DIGITS; d++) begin
            if (!ZERO_SUPPRESS || (cur_slot[4*d +: 4] != 4'h0))
                first_digit = DIG_W'(d);
        end

        sel_digit = in_ph ? digit_idx : first_digit;
        nib = 4'h0;
        for (int d = 0; d < SLOT_DIGITS; d++) begin
            if (sel_digit == DIG_W'(d))
                nib = cur_slot[4*d +: 4];
        end

        out_byte = (in_ph || cur_is_ph) ? hex_ascii(nib) : cur_char;
    end

    // Message sequencer and bit serializer; all outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            bus.tx    <= 1'b1;
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
            slot_q    <= '0;
            char_idx  <= '0;
            digit_idx <= '0;
            in_ph     <= 1'b0;
            sh_q      <= '1;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        slot_q    <= bus.din;
                        char_idx  <= '0;
                        in_ph     <= 1'b0;
                        bus.ready <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    sh_q     <= out_byte;
                    bus.tx   <= 1'b0;
                    bit_cnt  <= '0;
                    baud_cnt <= '0;
                    state    <= SEND;
                    if ((in_ph || cur_is_ph) && (sel_digit != '0)) begin
                        in_ph     <= 1'b1;
                        digit_idx <= sel_digit - DIG_W'(1);
                    end else begin
                        in_ph    <= 1'b0;
                        char_idx <= char_idx + IDX_W'(1);
                    end
                end
                SEND: begin
                    if (baud_cnt == BAUD_W'(DIV - 1)) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            if (!in_ph && (char_idx == IDX_W'(FORMAT_STR_LEN))) begin
                                state    <= DONE;
                                bus.done <= 1'b1;
                            end else begin
                                state <= LOAD;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            bus.tx  <= sh_q[0];
                            sh_q    <= {1'b1, sh_q[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DONE: begin
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
